// File: rtl/vec_op_sequencer_if.sv
// Bus bundle between vec_op_sequencer and the soc_system PIO word / on-chip RAM s2 port.
interface vec_op_sequencer_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned REGION_W = 4
);
  localparam int unsigned ADDR_W = REGION_W + IDX_W;

  logic [31:0]       pio_readdata;
  logic              pio_write;
  logic [31:0]       pio_writedata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
    input  pio_readdata, mem_readdata,
    output pio_write, pio_writedata, mem_address, mem_write, mem_writedata
  );

  modport slave (
    output pio_readdata, mem_readdata,
    input  pio_write, pio_writedata, mem_address, mem_write, mem_writedata
  );
endinterface

// File: rtl/vec_op_sequencer.sv
// Element-wise R[i] = op(A[i], B[i]) sequencer over the shared on-chip RAM, started from the HPS PIO word.
// Define VEC_SEQ_DOT_EN to add the dot_acc accumulator and its final write to R[all-ones index].
module vec_op_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned REGION_W = 4,
  parameter int unsigned A_REGION = 0,
  parameter int unsigned B_REGION = 1,
  parameter int unsigned R_REGION = 2,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  vec_op_sequencer_if.master    bus,
  output logic                  busy
`ifdef VEC_SEQ_DOT_EN
  ,
  output logic [2*DATA_W-1:0]   dot_acc
`endif
);

  localparam int unsigned ADDR_W = REGION_W + IDX_W;
  localparam int unsigned ACC_W  = 2 * DATA_W;
  localparam int unsigned CNT_W  = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [31:0] ST_BUSY = 32'd2;
  localparam logic [31:0] ST_DONE = 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_WR, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic              start_prev_q;
  logic [1:0]        op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              pio_write_q, pio_write_d;
  logic [31:0]       pio_wdata_q, pio_wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              start_edge;
  logic [DATA_W-1:0] result;
  logic              pio_unused;

`ifdef VEC_SEQ_DOT_EN
  logic [ACC_W-1:0]  dot_q, dot_d;
  logic              done_pend_q, done_pend_d;
`endif

  assign start_edge = bus.pio_readdata[0] & ~start_prev_q;
  assign pio_unused = ^bus.pio_readdata;

  // Element result from the captured A operand and the B word arriving this cycle
  always_comb begin
    result = op_a_q;
    unique case (op_q)
      2'd0:    result = op_a_q * bus.mem_readdata;
      2'd1:    result = op_a_q + bus.mem_readdata;
      2'd2:    result = op_a_q - bus.mem_readdata;
      default: result = op_a_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    wait_d      = wait_q;
    pio_write_d = 1'b0;
    pio_wdata_d = pio_wdata_q;
    addr_d      = addr_q;
    mem_write_d = 1'b0;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
`ifdef VEC_SEQ_DOT_EN
    dot_d       = dot_q;
    done_pend_d = done_pend_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef VEC_SEQ_DOT_EN
        // Done word goes out one cycle after the dot write so the two strobes never overlap
        if (done_pend_q) begin
          pio_write_d = 1'b1;
          pio_wdata_d = ST_DONE;
          done_pend_d = 1'b0;
        end else
`endif
        if (start_edge) begin
          op_d        = bus.pio_readdata[2:1];
          // A zero length field wraps to all-ones, i.e. the maximum 2**IDX_W elements
          last_d      = bus.pio_readdata[IDX_W+15:16] - IDX_W'(1);
          idx_d       = '0;
          busy_d      = 1'b1;
          pio_write_d = 1'b1;
          pio_wdata_d = ST_BUSY;
          state_d     = S_RD_A;
`ifdef VEC_SEQ_DOT_EN
          dot_d       = '0;
`endif
        end
      end
      S_RD_A: begin
        addr_d  = {REGION_W'(A_REGION), idx_q};
        wait_d  = CNT_W'(RD_LAT - 2);
        state_d = (RD_LAT > 1) ? S_WAIT_A : S_RD_B;
      end
      S_WAIT_A: begin
        wait_d = wait_q - CNT_W'(1);
        if (wait_q == '0) state_d = S_RD_B;
      end
      S_RD_B: begin
        op_a_d  = bus.mem_readdata;
        addr_d  = {REGION_W'(B_REGION), idx_q};
        wait_d  = CNT_W'(RD_LAT - 2);
        state_d = (RD_LAT > 1) ? S_WAIT_B : S_WR;
      end
      S_WAIT_B: begin
        wait_d = wait_q - CNT_W'(1);
        if (wait_q == '0) state_d = S_WR;
      end
      S_WR: begin
        addr_d      = {REGION_W'(R_REGION), idx_q};
        mem_wdata_d = result;
        mem_write_d = 1'b1;
`ifdef VEC_SEQ_DOT_EN
        dot_d       = dot_q + ACC_W'(op_a_q) * ACC_W'(bus.mem_readdata);
`endif
        if (idx_q == last_q) begin
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_RD_A;
        end
      end
      S_FIN: begin
`ifdef VEC_SEQ_DOT_EN
        addr_d      = {REGION_W'(R_REGION), {IDX_W{1'b1}}};
        mem_wdata_d = dot_q[DATA_W-1:0];
        mem_write_d = 1'b1;
        done_pend_d = 1'b1;
`else
        pio_write_d = 1'b1;
        pio_wdata_d = ST_DONE;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      op_q         <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      op_a_q       <= '0;
      wait_q       <= '0;
      pio_write_q  <= 1'b0;
      pio_wdata_q  <= '0;
      addr_q       <= '0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
`ifdef VEC_SEQ_DOT_EN
      dot_q        <= '0;
      done_pend_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.pio_readdata[0];
      op_q         <= op_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      op_a_q       <= op_a_d;
      wait_q       <= wait_d;
      pio_write_q  <= pio_write_d;
      pio_wdata_q  <= pio_wdata_d;
      addr_q       <= addr_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
`ifdef VEC_SEQ_DOT_EN
      dot_q        <= dot_d;
      done_pend_q  <= done_pend_d;
`endif
    end
  end

  assign bus.pio_write     = pio_write_q;
  assign bus.pio_writedata = pio_wdata_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_writedata = mem_wdata_q;
  assign busy              = busy_q;
`ifdef VEC_SEQ_DOT_EN
  assign dot_acc           = dot_q;
`endif

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Randomized bench for vec_op_sequencer: RAM model plus a whole-memory expected image per run.
`timescale 1ns/1ps
module tb_vec_op_sequencer;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned REGION_W = 4;
  localparam int unsigned ADDR_W   = REGION_W + IDX_W;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned NMAX     = 1 << IDX_W;
  localparam int unsigned A_BASE   = 0 * NMAX;
  localparam int unsigned B_BASE   = 1 * NMAX;
  localparam int unsigned R_BASE   = 2 * NMAX;
`ifdef VEC_SEQ_DOT_EN
  localparam int unsigned DOT_WR   = 1;
`else
  localparam int unsigned DOT_WR   = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef VEC_SEQ_DOT_EN
  logic [2*DATA_W-1:0] dot_acc;
`endif

  vec_op_sequencer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .REGION_W(REGION_W)) bus ();

  vec_op_sequencer #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .REGION_W(REGION_W),
    .A_REGION(0), .B_REGION(1), .R_REGION(2), .RD_LAT(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef VEC_SEQ_DOT_EN
    ,
    .dot_acc (dot_acc)
`endif
  );

  always #10 clk = ~clk;

  // RAM model: address registered at one edge, its data sampled at the next edge
  logic [31:0] ram      [DEPTH];
  logic [31:0] load_img [DEPTH];
  logic [31:0] exp_img  [DEPTH];
  logic        load_req;

  always @(posedge clk) begin
    if (load_req) ram <= load_img;
    else if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
  end
  assign bus.mem_readdata = ram[bus.mem_address];

  int unsigned n_wr = 0, n_busy = 0, n_both = 0;
  logic [31:0] pio_log[$];

  always @(negedge clk) begin
    if (bus.mem_write) n_wr++;
    if (busy) n_busy++;
    if (bus.mem_write && bus.pio_write) n_both++;
    if (bus.pio_write) pio_log.push_back(bus.pio_writedata);
  end

  int unsigned n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'd0:    return a * b;
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] ctl_word(input logic [1:0] op, input int unsigned len_f,
                                           input logic start);
    logic [31:0] w;
    w = '0;
    w[0] = start;
    w[2:1] = op;
    w[IDX_W+15:16] = IDX_W'(len_f);
    return w;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < int'(DEPTH); k++) load_img[k] = $urandom();
  endtask

  task automatic load_ram();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  function automatic int unsigned ram_diffs();
    int unsigned bad = 0;
    for (int k = 0; k < int'(DEPTH); k++) if (ram[k] !== exp_img[k]) bad++;
    return bad;
  endfunction

  task automatic run_vec(input string tag, input logic [1:0] op, input int unsigned len_f,
                         input bit toggle);
    int unsigned n, wr0, busy0, both0, pio0;
    logic [63:0] dot;
    bit seen;
    n = (len_f == 0) ? NMAX : len_f;
    exp_img = load_img;
    dot = '0;
    for (int i = 0; i < int'(n); i++) begin
      exp_img[R_BASE+i] = ref_op(op, load_img[A_BASE+i], load_img[B_BASE+i]);
      dot += 64'(load_img[A_BASE+i]) * 64'(load_img[B_BASE+i]);
    end
`ifdef VEC_SEQ_DOT_EN
    exp_img[R_BASE+NMAX-1] = dot[31:0];
`endif
    load_ram();
    wr0 = n_wr; busy0 = n_busy; both0 = n_both; pio0 = pio_log.size();
    bus.pio_readdata = ctl_word(op, len_f, 1'b1);
    seen = 1'b0;
    for (int cyc = 0; cyc < int'(3 * n + 40) && !seen; cyc++) begin
      step();
      if (toggle && cyc == 4) bus.pio_readdata = ctl_word(~op, len_f + 3, 1'b0);
      if (toggle && cyc == 7) bus.pio_readdata = ctl_word(~op, len_f + 3, 1'b1);
      if (pio_log.size() >= pio0 + 2) seen = 1'b1;
    end
    repeat (10) step();
    chk($sformatf("%s_done_seen", tag), 64'(seen), 64'd1);
    chk($sformatf("%s_writes", tag), 64'(n_wr - wr0), 64'(n + DOT_WR));
    chk($sformatf("%s_busy_cycles", tag), 64'(n_busy - busy0), 64'(3 * n));
    chk($sformatf("%s_pio_count", tag), 64'(pio_log.size() - pio0), 64'd2);
    if (pio_log.size() >= pio0 + 2) begin
      chk($sformatf("%s_pio_busy", tag), 64'(pio_log[pio0]), 64'd2);
      chk($sformatf("%s_pio_done", tag), 64'(pio_log[pio0+1]), 64'd0);
    end
    chk($sformatf("%s_strobe_overlap", tag), 64'(n_both - both0), 64'd0);
    chk($sformatf("%s_ram_diffs", tag), 64'(ram_diffs()), 64'd0);
`ifdef VEC_SEQ_DOT_EN
    chk($sformatf("%s_dot_acc", tag), dot_acc, dot);
`endif
    bus.pio_readdata = '0;
    repeat (2) step();
  endtask

  initial begin
    int unsigned wr0;
    bit seen;
    logic [1:0] op;

    reset = 1'b1;
    load_req = 1'b0;
    bus.pio_readdata = '0;
    repeat (3) step();
    chk("reset_ctl", {bus.pio_write, bus.mem_write, busy, bus.mem_address}, 64'd0);
    chk("reset_data", {bus.pio_writedata, bus.mem_writedata}, 64'd0);
`ifdef VEC_SEQ_DOT_EN
    chk("reset_dot", dot_acc, 64'd0);
`endif
    reset = 1'b0;
    repeat (2) step();

    // A[i]=i+1, B[i]=3, multiply, four elements
    fill_random();
    for (int i = 0; i < 4; i++) begin
      load_img[A_BASE+i] = 32'(i + 1);
      load_img[B_BASE+i] = 32'd3;
    end
    run_vec("mul4", 2'd0, 4, 1'b0);
    chk("mul4_r3", 64'(ram[R_BASE+3]), 64'd12);

    // Wrap-around of subtract and add
    fill_random();
    load_img[A_BASE] = 32'd0;
    load_img[B_BASE] = 32'd1;
    run_vec("sub_wrap", 2'd2, 1, 1'b0);
    chk("sub_wrap_r0", 64'(ram[R_BASE]), 64'hFFFF_FFFF);
    fill_random();
    load_img[A_BASE] = 32'hFFFF_FFFF;
    load_img[B_BASE] = 32'd2;
    run_vec("add_wrap", 2'd1, 1, 1'b0);
    chk("add_wrap_r0", 64'(ram[R_BASE]), 64'd1);

    // Zero length field runs the full 1024 elements
    fill_random();
    for (int i = 0; i < int'(NMAX); i++) load_img[A_BASE+i] = 32'(i);
    run_vec("copy_max", 2'd3, 0, 1'b0);

    // Start toggled mid-run with a different op/len must not restart or retarget
    fill_random();
    run_vec("toggle", 2'd1, 12, 1'b1);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_vec($sformatf("rand%0d", r), 2'($urandom_range(0, 3)), $urandom_range(1, 40), 1'b0);
    end

    // Reset during element 2 of an 8-element run
    fill_random();
    op = 2'($urandom_range(0, 3));
    exp_img = load_img;
    for (int i = 0; i < 2; i++)
      exp_img[R_BASE+i] = ref_op(op, load_img[A_BASE+i], load_img[B_BASE+i]);
    load_ram();
    wr0 = n_wr;
    bus.pio_readdata = ctl_word(op, 8, 1'b1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      step();
      if (n_wr - wr0 >= 2) seen = 1'b1;
    end
    chk("midrst_reached", 64'(seen), 64'd1);
    step();
    reset = 1'b1;
    #1;
    chk("midrst_ctl", {bus.pio_write, bus.mem_write, busy, bus.mem_address}, 64'd0);
    chk("midrst_data", {bus.pio_writedata, bus.mem_writedata}, 64'd0);
    bus.pio_readdata = '0;
    repeat (2) step();
    reset = 1'b0;
    repeat (40) step();
    chk("midrst_writes", 64'(n_wr - wr0), 64'd2);
    chk("midrst_ram_diffs", 64'(ram_diffs()), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
